// File: rtl/bounce_gen.sv
// rtl/bounce_gen.sv - switch contact bounce emulator with LFSR-randomised toggle gaps
`timescale 1ns/1ps
module bounce_gen #(
    parameter int          BOUNCES  = 4,
    parameter int          GAP_W    = 8,
    parameter int          HOLD_CYC = 1000,
    parameter logic [15:0] SEED     = 16'hACE1
) (
    input  logic clk,
    input  logic reset,
    input  logic level,
    input  logic enable,
    output logic sw,
    output logic busy,
    output logic done
);

    // hold_cnt must hold HOLD_CYC-1; keep at least one bit when HOLD_CYC is 1
    localparam int                HOLD_W      = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
    localparam logic [4:0]        LAST_TOGGLE = 5'(2 * BOUNCES + 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD   = HOLD_W'(HOLD_CYC - 1);

    typedef enum logic [1:0] {
        IDLE,
        BOUNCE,
        HOLD
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [15:0]       lfsr;
    logic              lfsr_fb;
    logic              target;
    logic              target_nxt;
    logic              sw_nxt;
    logic              done_nxt;
    logic [4:0]        toggle_cnt;
    logic [4:0]        toggle_nxt;
    logic [GAP_W-1:0]  gap_cnt;
    logic [GAP_W-1:0]  gap_nxt;
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] hold_nxt;

    // x^16 + x^14 + x^13 + x^11 + 1, maximal length, so a nonzero seed never reaches zero
    assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

    // busy covers every cycle the sequencer owns sw
    assign busy = (state != IDLE);

    // LFSR free-runs in every state so gap values keep changing between toggles
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr <= SEED;
        end else begin
            lfsr <= {lfsr[14:0], lfsr_fb};
        end
    end

    // state and datapath registers; reset aborts any sequence in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            sw         <= 1'b0;
            done       <= 1'b0;
            target     <= 1'b0;
            toggle_cnt <= 5'd0;
            gap_cnt    <= '0;
            hold_cnt   <= '0;
        end else begin
            state      <= state_nxt;
            sw         <= sw_nxt;
            done       <= done_nxt;
            target     <= target_nxt;
            toggle_cnt <= toggle_nxt;
            gap_cnt    <= gap_nxt;
            hold_cnt   <= hold_nxt;
        end
    end

    // next-state logic: level/enable are only looked at while IDLE, so target stays latched
    always_comb begin
        state_nxt  = state;
        sw_nxt     = sw;
        target_nxt = target;
        toggle_nxt = toggle_cnt;
        gap_nxt    = gap_cnt;
        hold_nxt   = hold_cnt;
        done_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (level != sw) begin
                    if (!enable) begin
                        sw_nxt   = level;
                        done_nxt = 1'b1;
                    end else begin
                        target_nxt = level;
                        sw_nxt     = level;
                        toggle_nxt = 5'd1;
                        gap_nxt    = lfsr[GAP_W-1:0];
                        state_nxt  = BOUNCE;
                    end
                end
            end
            BOUNCE: begin
                if (gap_cnt != '0) begin
                    gap_nxt = gap_cnt - 1'b1;
                end else if (toggle_cnt < LAST_TOGGLE) begin
                    sw_nxt     = ~sw;
                    toggle_nxt = toggle_cnt + 5'd1;
                    gap_nxt    = lfsr[GAP_W-1:0];
                end else begin
                    // odd toggle count leaves sw at target already; drive it explicitly
                    sw_nxt    = target;
                    hold_nxt  = HOLD_LOAD;
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (hold_cnt != '0) begin
                    hold_nxt = hold_cnt - 1'b1;
                end else begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_bounce_gen.sv
// tb/tb_bounce_gen.sv - scoreboard bench for bounce_gen
`timescale 1ns/1ps
module tb_bounce_gen;

    localparam int          NB_A  = 4;
    localparam int          NB_B  = 0;
    localparam int          GAP_W = 8;
    localparam int          HOLD  = 20;
    localparam logic [15:0] SEED  = 16'hACE1;

    typedef struct {
        logic sw;
        int   edges;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic level_a = 1'b0;
    logic enable_a = 1'b0;
    logic level_b = 1'b0;
    logic enable_b = 1'b0;
    logic sw_a, busy_a, done_a;
    logic sw_b, busy_b, done_b;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    bounce_gen #(.BOUNCES(NB_A), .GAP_W(GAP_W), .HOLD_CYC(HOLD), .SEED(SEED)) dut (
        .clk(clk), .reset(reset), .level(level_a), .enable(enable_a),
        .sw(sw_a), .busy(busy_a), .done(done_a)
    );

    bounce_gen #(.BOUNCES(NB_B), .GAP_W(GAP_W), .HOLD_CYC(HOLD), .SEED(SEED)) dut0 (
        .clk(clk), .reset(reset), .level(level_b), .enable(enable_b),
        .sw(sw_b), .busy(busy_b), .done(done_b)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // reference LFSR and cycle counter
    logic [15:0] lfsr_m = SEED;
    logic [15:0] lfsr_used = SEED;
    int          cyc = 0;

    always @(posedge clk) begin
        lfsr_used <= lfsr_m;
        if (reset) lfsr_m <= SEED;
        else       lfsr_m <= {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
        cyc <= cyc + 1;
    end

    // scoreboard and monitor state, index 0 = dut, 1 = dut0
    exp_t q_a[$];
    exp_t q_b[$];
    int   ivl_log[$];
    int   edges[2];
    int   exp_edge[2];
    int   exp_done[2];
    int   start_c[2];
    int   busy_cnt[2];
    int   last_e[2];
    logic prev_sw[2];

    function automatic int nb(input int i);
        return (i == 0) ? NB_A : NB_B;
    endfunction

    function automatic int qsize(input int i);
        return (i == 0) ? q_a.size() : q_b.size();
    endfunction

    task automatic push_exp(input int i, input logic s, input int n);
        exp_t e;
        e.sw = s;
        e.edges = n;
        if (i == 0) q_a.push_back(e);
        else        q_b.push_back(e);
    endtask

    task automatic mon(input int i, input logic s, input logic b, input logic d, input logic lvl);
        int   g;
        int   ivl;
        exp_t e;
        if (reset) begin
            edges[i] = 0;
            exp_edge[i] = -1;
            exp_done[i] = -1;
            busy_cnt[i] = 0;
            prev_sw[i] = s;
            return;
        end
        if (s !== prev_sw[i]) begin
            edges[i]++;
            if (edges[i] == 1) begin
                start_c[i] = cyc;
                busy_cnt[i] = 0;
            end else begin
                ivl = cyc - last_e[i];
                check("gap_range", (ivl >= 1 && ivl <= (1 << GAP_W)), 1);
                if (i == 0) ivl_log.push_back(ivl);
            end
            if (exp_edge[i] >= 0) check("edge_time", cyc, exp_edge[i]);
            exp_edge[i] = -1;
            last_e[i] = cyc;
            if (b) begin
                g = int'(lfsr_used[GAP_W-1:0]) + 1;
                if (edges[i] < 2 * nb(i) + 1) exp_edge[i] = cyc + g;
                else                          exp_done[i] = cyc + g + HOLD;
            end else begin
                exp_done[i] = cyc;
            end
        end else if (exp_edge[i] >= 0 && cyc >= exp_edge[i]) begin
            check("edge_missing", 0, 1);
            exp_edge[i] = -1;
        end
        if (b) busy_cnt[i]++;
        if (d) begin
            check("done_time", cyc, exp_done[i]);
            check("done_busy", b, 0);
            check("busy_len", busy_cnt[i], cyc - start_c[i]);
            if (qsize(i) == 0) begin
                check("spurious_done", 0, 1);
            end else begin
                e = (i == 0) ? q_a.pop_front() : q_b.pop_front();
                check("edge_count", edges[i], e.edges);
                check("final_sw", s, e.sw);
            end
            edges[i] = 0;
            exp_done[i] = -1;
            exp_edge[i] = -1;
            // a pending transition must start on the very next edge
            if (qsize(i) != 0 && lvl != s) exp_edge[i] = cyc + 1;
        end else if (exp_done[i] >= 0 && cyc >= exp_done[i]) begin
            check("done_missing", 0, 1);
            exp_done[i] = -1;
        end
        prev_sw[i] = s;
    endtask

    always @(negedge clk) begin
        mon(0, sw_a, busy_a, done_a, level_a);
        mon(1, sw_b, busy_b, done_b, level_b);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        level_a = 1'b0;
        level_b = 1'b0;
        q_a.delete();
        q_b.delete();
        tick(2);
        reset = 1'b0;
    endtask

    task automatic wait_q(input int i, input int budget);
        int n;
        n = 0;
        while (qsize(i) != 0 && n < budget) begin
            tick(1);
            n++;
        end
        if (qsize(i) != 0) check("timeout", 0, 1);
    endtask

    int ref_ivl[$];
    int zero_hits;
    int per;
    int mism;
    logic [15:0] v0;

    initial begin
        do_reset();
        check("rst_sw", sw_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        check("rst_lfsr", dut.lfsr, SEED);
        check("rst_sw_b", sw_b, 0);

        // reference run, aborted by reset mid-bounce
        enable_a = 1'b1;
        tick(3);
        level_a = 1'b1;
        push_exp(0, 1'b1, 2 * NB_A + 1);
        for (int n = 0; n < 2000 && ivl_log.size() < 3; n++) tick(1);
        check("ivl_logged", ivl_log.size() >= 3, 1);
        ref_ivl = ivl_log;
        check("mid_busy", busy_a, 1);
        reset = 1'b1;
        level_a = 1'b0;
        q_a.delete();
        tick(1);
        check("abort_sw", sw_a, 0);
        check("abort_busy", busy_a, 0);
        tick(1);
        reset = 1'b0;
        ivl_log.delete();

        // identical timing after reset must replay identical gaps, then complete
        tick(3);
        level_a = 1'b1;
        push_exp(0, 1'b1, 2 * NB_A + 1);
        wait_q(0, 4000);
        check("seq_sw", sw_a, 1);
        for (int k = 0; k < 3; k++) begin
            if (k < ivl_log.size() && k < ref_ivl.size()) check("repeat_gap", ivl_log[k], ref_ivl[k]);
            else check("repeat_gap_len", 0, 1);
        end

        // clean pass-through in both directions
        enable_a = 1'b0;
        level_a = 1'b0;
        push_exp(0, 1'b0, 1);
        tick(1);
        check("pt_sw0", sw_a, 0);
        check("pt_done0", done_a, 1);
        check("pt_busy0", busy_a, 0);
        wait_q(0, 10);
        level_a = 1'b1;
        push_exp(0, 1'b1, 1);
        tick(1);
        check("pt_sw1", sw_a, 1);
        check("pt_done1", done_a, 1);
        check("pt_busy1", busy_a, 0);
        wait_q(0, 10);
        level_a = 1'b0;
        push_exp(0, 1'b0, 1);
        wait_q(0, 10);

        // level 0->1->0 and enable wiggle during BOUNCE: finish to 1, then chain to 0
        enable_a = 1'b1;
        level_a = 1'b1;
        push_exp(0, 1'b1, 2 * NB_A + 1);
        tick(5);
        check("chain_busy", busy_a, 1);
        level_a = 1'b0;
        push_exp(0, 1'b0, 2 * NB_A + 1);
        enable_a = 1'b0;
        tick(4);
        enable_a = 1'b1;
        wait_q(0, 8000);
        check("chain_sw", sw_a, 0);

        // zero bounces: a single edge each way
        enable_b = 1'b1;
        level_b = 1'b1;
        push_exp(1, 1'b1, 1);
        wait_q(1, 1000);
        check("b0_sw1", sw_b, 1);
        level_b = 1'b0;
        push_exp(1, 1'b0, 1);
        wait_q(1, 1000);
        check("b0_sw0", sw_b, 0);

        // free-run LFSR
        zero_hits = 0;
        per = 0;
        mism = 0;
        @(negedge clk);
        v0 = dut.lfsr;
        for (int n = 1; n <= 70000; n++) begin
            @(negedge clk);
            if (dut.lfsr == 16'h0) zero_hits++;
            if (dut.lfsr !== lfsr_m) mism++;
            if (per == 0 && dut.lfsr == v0) per = n;
        end
        check("lfsr_zero", zero_hits, 0);
        check("lfsr_period", per, 65535);
        check("lfsr_model", mism, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
